// File: rtl/support_set_ctrl.sv
// rtl/support_set_ctrl.sv - support-set store: appends atom indices to a RAM and streams them back in order
module support_set_ctrl #(
  parameter int AW    = 6,
  parameter int DW    = 16,
  parameter int DEPTH = 64
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          clr,
  input  logic          push_valid,
  input  logic [DW-1:0] push_idx,
  output logic          push_ready,
  input  logic          scan_start,
  output logic          scan_busy,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [AW:0]   count,
  output logic          full,
  output logic          ovf,
  output logic [AW-1:0] ram_A,
  output logic          ram_WE,
  output logic          ram_OE,
  output logic [DW-1:0] ram_D,
  input  logic [DW-1:0] ram_Q
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t        state;
  logic [AW-1:0] ptr;
  logic          drain_cnt;
  logic          rd_last;
  logic          scan_end;

  assign scan_end   = ({1'b0, ptr} == (count - 1'b1));
  assign full       = (count == DEPTH_C);
  // RST gates the write strobe so the RAM sees no write while reset is held
  assign push_ready = !RST && (state == IDLE) && !full && !clr && !scan_start;
  assign ram_WE     = push_valid && push_ready;
  assign ram_A      = (state == SCAN) ? ptr : count[AW-1:0];
  assign ram_D      = push_idx;
  assign scan_busy  = (state != IDLE);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      count     <= '0;
      ovf       <= 1'b0;
      ptr       <= '0;
      drain_cnt <= 1'b0;
      rd_last   <= 1'b0;
      ram_OE    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      // read pipeline: address in SCAN, RAM data one cycle later, registered output after that
      ram_OE    <= (state == SCAN);
      rd_last   <= (state == SCAN) && scan_end;
      out_valid <= ram_OE;
      out_last  <= rd_last;
      if (ram_OE) out_data <= ram_Q;

      case (state)
        IDLE: begin
          if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
          end else if (scan_start) begin
            ptr       <= '0;
            drain_cnt <= 1'b0;
            state     <= (count == '0) ? DRAIN : SCAN;
          end else if (push_valid) begin
            if (full) ovf <= 1'b1;
            else      count <= count + 1'b1;
          end
        end
        SCAN: begin
          if (scan_end) state <= DRAIN;
          else          ptr   <= ptr + 1'b1;
        end
        DRAIN: begin
          if (drain_cnt) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_support_set_ctrl.sv
// tb/tb_support_set_ctrl.sv - directed scoreboard bench for support_set_ctrl
module tb_support_set_ctrl;

  logic CK = 1'b0;
  logic RST;
  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc++;

  // instance A: default geometry
  logic        clr_a, push_valid_a, push_ready_a, scan_start_a, scan_busy_a;
  logic        out_valid_a, out_last_a, full_a, ovf_a, ram_WE_a, ram_OE_a;
  logic [15:0] push_idx_a, out_data_a, ram_D_a, ram_Q_a;
  logic [6:0]  count_a;
  logic [5:0]  ram_A_a, aq_a;
  logic [15:0] mem_a [0:63];

  // instance B: DEPTH=4 for the full/overflow boundary
  logic        clr_b, push_valid_b, push_ready_b, scan_start_b, scan_busy_b;
  logic        out_valid_b, out_last_b, full_b, ovf_b, ram_WE_b, ram_OE_b;
  logic [15:0] push_idx_b, out_data_b, ram_D_b, ram_Q_b;
  logic [2:0]  count_b;
  logic [1:0]  ram_A_b, aq_b;
  logic [15:0] mem_b [0:3];

  support_set_ctrl dut_a (
    .CK(CK), .RST(RST), .clr(clr_a), .push_valid(push_valid_a), .push_idx(push_idx_a),
    .push_ready(push_ready_a), .scan_start(scan_start_a), .scan_busy(scan_busy_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_last(out_last_a), .count(count_a),
    .full(full_a), .ovf(ovf_a), .ram_A(ram_A_a), .ram_WE(ram_WE_a), .ram_OE(ram_OE_a),
    .ram_D(ram_D_a), .ram_Q(ram_Q_a)
  );

  support_set_ctrl #(.AW(2), .DW(16), .DEPTH(4)) dut_b (
    .CK(CK), .RST(RST), .clr(clr_b), .push_valid(push_valid_b), .push_idx(push_idx_b),
    .push_ready(push_ready_b), .scan_start(scan_start_b), .scan_busy(scan_busy_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b), .count(count_b),
    .full(full_b), .ovf(ovf_b), .ram_A(ram_A_b), .ram_WE(ram_WE_b), .ram_OE(ram_OE_b),
    .ram_D(ram_D_b), .ram_Q(ram_Q_b)
  );

  // synchronous RAM models: address latched on the edge, data returned while OE is high
  always @(posedge CK) begin
    if (ram_WE_a) mem_a[ram_A_a] <= ram_D_a;
    aq_a <= ram_A_a;
    if (ram_WE_b) mem_b[ram_A_b] <= ram_D_b;
    aq_b <= ram_A_b;
  end
  assign ram_Q_a = ram_OE_a ? mem_a[aq_a] : 16'h0;
  assign ram_Q_b = ram_OE_b ? mem_b[aq_b] : 16'h0;

  int checks = 0;
  int errors = 0;
  logic [15:0] model[$];
  logic [16:0] sb[$];
  int first_valid_cyc;
  int valid_cnt;
  int scan_cyc;
  int busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic push_a(input logic [15:0] d);
    push_valid_a = 1'b1;
    push_idx_a   = d;
    @(negedge CK);
    chk("push_ready", push_ready_a, 1);
    chk("push_we", ram_WE_a, 1);
    chk("push_addr", ram_A_a, model.size());
    chk("push_data", ram_D_a, d);
    tick();
    push_valid_a = 1'b0;
    model.push_back(d);
  endtask

  task automatic wait_idle(output int nbusy);
    bit done;
    nbusy = 0;
    done  = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CK);
      if (!scan_busy_a) done = 1;
      else nbusy++;
    end
    chk("scan_timeout", done, 1);
  endtask

  task automatic start_scan();
    first_valid_cyc = -1;
    valid_cnt       = 0;
    foreach (model[i]) sb.push_back({(i == model.size() - 1), model[i]});
    scan_start_a = 1'b1;
    scan_cyc     = cyc;
    tick();
    scan_start_a = 1'b0;
  endtask

  always @(negedge CK) begin
    logic [16:0] e;
    if (scan_busy_a) chk("we_in_scan", ram_WE_a, 0);
    if (out_valid_a) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      valid_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", out_valid_a, 0);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data_a, e[15:0]);
        chk("out_last", out_last_a, e[16]);
      end
    end else begin
      chk("last_no_valid", out_last_a, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    clr_a = 0; push_valid_a = 0; push_idx_a = 0; scan_start_a = 0;
    clr_b = 0; push_valid_b = 0; push_idx_b = 0; scan_start_b = 0;
    repeat (2) @(posedge CK);
    #1;
    chk("rst_count", count_a, 0);
    chk("rst_busy", scan_busy_a, 0);
    chk("rst_valid", out_valid_a, 0);
    chk("rst_oe", ram_OE_a, 0);
    chk("rst_we", ram_WE_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_data", out_data_a, 0);
    chk("rst_count_b", count_b, 0);
    RST = 1'b0;
    tick();

    // three appends then an in-order readback
    push_a(16'h0011);
    push_a(16'h0022);
    push_a(16'h0033);
    @(negedge CK);
    chk("count3", count_a, 3);
    chk("ovf_clean", ovf_a, 0);
    tick();
    start_scan();
    wait_idle(busy);
    chk("scan3_busy", busy, 5);
    chk("scan3_valid_cnt", valid_cnt, 3);
    chk("scan3_latency", first_valid_cyc, scan_cyc + 3);
    chk("scan3_sb_empty", sb.size(), 0);
    chk("scan3_count_held", count_a, 3);
    tick();

    // empty scan goes straight through DRAIN
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    model.delete();
    chk("clr_count", count_a, 0);
    start_scan();
    wait_idle(busy);
    chk("scan0_busy", busy, 2);
    chk("scan0_valid_cnt", valid_cnt, 0);
    tick();

    // clr beats scan_start and push
    push_a(16'h00A1);
    push_a(16'h00A2);
    clr_a = 1'b1; scan_start_a = 1'b1; push_valid_a = 1'b1; push_idx_a = 16'h0099;
    @(negedge CK);
    chk("prio_ready", push_ready_a, 0);
    chk("prio_we", ram_WE_a, 0);
    tick();
    clr_a = 1'b0; scan_start_a = 1'b0; push_valid_a = 1'b0;
    model.delete();
    @(negedge CK);
    chk("prio_count", count_a, 0);
    chk("prio_busy", scan_busy_a, 0);
    tick();
    @(negedge CK);
    chk("prio_busy2", scan_busy_a, 0);
    tick();

    // push held during a scan is stalled, then accepted
    push_a(16'h0051);
    push_a(16'h0052);
    start_scan();
    push_valid_a = 1'b1;
    push_idx_a   = 16'h0053;
    busy = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CK);
      if (!scan_busy_a) break;
      busy++;
      chk("scan_push_ready", push_ready_a, 0);
      chk("scan_push_count", count_a, 2);
    end
    chk("scan2_busy", busy, 4);
    chk("post_push_ready", push_ready_a, 1);
    chk("post_push_we", ram_WE_a, 1);
    chk("post_push_addr", ram_A_a, 2);
    tick();
    push_valid_a = 1'b0;
    model.push_back(16'h0053);
    @(negedge CK);
    chk("post_push_count", count_a, 3);
    chk("scan2_sb_empty", sb.size(), 0);
    tick();

    // reset in the middle of an 8-entry scan
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    model.delete();
    for (int i = 0; i < 8; i++) push_a(16'h0100 + 16'(i));
    start_scan();
    repeat (5) tick();
    chk("pre_rst_valid_cnt", valid_cnt, 3);
    RST = 1'b1;
    #1;
    chk("mid_rst_busy", scan_busy_a, 0);
    chk("mid_rst_valid", out_valid_a, 0);
    chk("mid_rst_count", count_a, 0);
    chk("mid_rst_oe", ram_OE_a, 0);
    sb.delete();
    model.delete();
    tick();
    RST = 1'b0;
    tick();
    start_scan();
    wait_idle(busy);
    chk("after_rst_busy", busy, 2);
    chk("after_rst_valid_cnt", valid_cnt, 0);
    tick();

    // DEPTH=4 instance: fill, overflow, clear
    for (int i = 0; i < 5; i++) begin
      push_valid_b = 1'b1;
      push_idx_b   = 16'h0200 + 16'(i);
      @(negedge CK);
      chk("b_push_ready", push_ready_b, (i < 4) ? 1 : 0);
      chk("b_push_we", ram_WE_b, (i < 4) ? 1 : 0);
      tick();
    end
    push_valid_b = 1'b0;
    @(negedge CK);
    chk("b_full", full_b, 1);
    chk("b_ovf", ovf_b, 1);
    chk("b_count", count_b, 4);
    chk("b_ready_full", push_ready_b, 0);
    chk("b_mem3", mem_b[3], 16'h0203);
    tick();
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    @(negedge CK);
    chk("b_clr_count", count_b, 0);
    chk("b_clr_ovf", ovf_b, 0);
    chk("b_clr_full", full_b, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
